// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues imem word reads and buffers returned words (FETCH_RANGE_CHECK_EN adds the NOP/out_err range check).
// Latency: issue in cycle N, word buffered at end of N+1, out_valid in N+2; a redirect target is valid 3 cycles after the redirect edge.
// Backpressure: no issue once buffered + inflight - popping words reach BUF_DEPTH; out_pc/out_ins hold while out_ready is low.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          ADDR_W    = 6,
  parameter int          MEM_WORDS = 51,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_ins,
  output logic              out_err
);

  localparam logic [31:0] NOP = 32'h0000_0033;
  localparam int          CW  = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } ent_t;

  if (BUF_DEPTH < 2) begin : g_bad_depth
    $error("imem_fetch_ctrl: BUF_DEPTH must be >= 2");
  end
  if (MEM_WORDS < 1 || MEM_WORDS > (1 << ADDR_W)) begin : g_bad_words
    $error("imem_fetch_ctrl: MEM_WORDS must be in 1..2**ADDR_W");
  end

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   issue_pc_q;
  logic          inflight_q;
  logic [CW-1:0] count_q, count_d;
  ent_t          fifo_q [BUF_DEPTH];
  ent_t          fifo_d [BUF_DEPTH];
  ent_t          ret_ent;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // Credit: words already owed to the FIFO plus this read must still fit after the pop.
  assign occ       = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_RESET: state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      ST_RUN:   state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RESET;
    endcase
    if (state_q != ST_RESET && !rst && !redirect_valid && occ < (CW+1)'(BUF_DEPTH))
      issue = 1'b1;
  end

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q[ADDR_W+1:2];

  always_comb begin
    ret_ent.pc  = issue_pc_q;
    ret_ent.ins = imem_rdata;
    ret_ent.err = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
    if (issue_pc_q[31:2] >= 30'(MEM_WORDS)) begin
      ret_ent.ins = NOP;
      ret_ent.err = 1'b1;
    end
`endif
  end

  // A read returning in a redirect cycle belongs to the old path and is dropped.
  assign push = inflight_q & ~redirect_valid;

  // Entry 0 is the output register; it is only overwritten by a real successor so
  // the outputs keep their last values when the FIFO drains or is flushed.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < BUF_DEPTH; i++) fifo_d[i] = fifo_q[i];
    if (redirect_valid) begin
      count_d = '0;
    end else begin
      if (pop) begin
        if (count_q > CW'(1)) begin
          for (int i = 0; i < BUF_DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
        end
        count_d = count_q - CW'(1);
      end
      if (push) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          if (CW'(i) == count_d) fifo_d[i] = ret_ent;
        end
        count_d = count_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) fifo_q[i] <= '{pc: 32'h0, ins: NOP, err: 1'b0};
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      count_q    <= count_d;
      for (int i = 0; i < BUF_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      if (redirect_valid) begin
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        issue_pc_q <= fetch_pc_q;
      end
    end
  end

  assign out_pc  = fifo_q[0].pc;
  assign out_ins = fifo_q[0].ins;
`ifdef FETCH_RANGE_CHECK_EN
  assign out_err = fifo_q[0].err;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural synchronous memory and an expected-output queue.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0033;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_err;

  logic [31:0] mem [64];
  exp_t        q [$];
  int          checks = 0;
  int          errors = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ins        (out_ins),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem[pc[7:2]];
    e.err = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
    if (pc[31:2] >= 30'd51) begin
      e.ins = NOP;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) q.push_back(mk(start + 32'(4 * i)));
  endtask

  // Called at a negedge; returns at the first negedge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    #2 q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; the transfer of this cycle is scored before the queue is replaced.
  task automatic do_redirect(input logic [31:0] target, input int n);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #2;
    chk("redir_prior_drained", q.size(), 0);
    q.delete();
    chk("redir_no_issue", imem_en, 0);
    push_stream({target[31:2], 2'b00}, n);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed pc=%h expected=no transfer", out_pc);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_ins", out_ins, e.ins);
        chk("sb_err", out_err, e.err);
      end
    end
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = (k < 51) ? 32'(k + 1) : (32'hBAD0_0000 | 32'(k));
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ins", out_ins, NOP);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_imem_en", imem_en, 0);

    // Streaming from reset with out_ready high
    out_ready = 1'b1;
    push_stream(32'h0, 8);
    rst = 1'b0;
    #1 chk("t1_reset_cycle_en", imem_en, 0);
    @(negedge clk);
    chk("t1_first_issue", imem_en, 1);
    chk("t1_first_addr", imem_addr, 0);
    chk("t1_valid_c1", out_valid, 0);
    @(negedge clk); chk("t1_valid_c2", out_valid, 0);
    @(negedge clk); chk("t1_valid_c3", out_valid, 1);
    repeat (7) begin @(negedge clk); chk("t1_no_gap", out_valid, 1); end
    @(negedge clk);
    out_ready = 1'b0;
    chk("t1_drained", q.size(), 0);

    // Backpressure for 5 cycles after the first valid
    do_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_pc", out_pc, 0);
      chk("t2_hold_ins", out_ins, 1);
      chk("t2_credit_stop", imem_en, 0);
      @(negedge clk);
    end
    push_stream(32'h0, 3);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    chk("t2_no_loss", q.size(), 0);
    chk("t2_next_pc", out_pc, 32'hC);

    // Redirect while pc 8 is presented
    do_reset();
    out_ready = 1'b1;
    push_stream(32'h0, 3);
    repeat (5) @(negedge clk);
    chk("t3_at_pc8", out_pc, 32'h8);
    do_redirect(32'h40, 3);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t3_valid_r1", out_valid, 0);
    chk("t3_issue_r1", imem_en, 1);
    chk("t3_addr_r1", imem_addr, 16);
    @(negedge clk); chk("t3_valid_r2", out_valid, 0);
    @(negedge clk);
    chk("t3_valid_r3", out_valid, 1);
    chk("t3_pc_r3", out_pc, 32'h40);
    chk("t3_ins_r3", out_ins, 32'd17);

    // Back-to-back redirects: the second one wins
    @(negedge clk);
    @(negedge clk);
    do_redirect(32'h20, 0);
    @(negedge clk);
    do_redirect(32'h30, 1);
    chk("t4_valid_s0", out_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_valid_s1", out_valid, 0);
    @(negedge clk); chk("t4_valid_s2", out_valid, 0);
    @(negedge clk);
    chk("t4_valid_s3", out_valid, 1);
    chk("t4_pc_s3", out_pc, 32'h30);
    chk("t4_ins_s3", out_ins, 32'd13);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset pulse while the FIFO is full
    repeat (3) @(negedge clk);
    chk("t5_full_valid", out_valid, 1);
    chk("t5_full_pc", out_pc, 32'h34);
    chk("t5_full_no_issue", imem_en, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_ins_nop", out_ins, NOP);
    chk("t5_pc", out_pc, 0);
    chk("t5_err", out_err, 0);
    chk("t5_reset_cycle_en", imem_en, 0);
    push_stream(32'h0, 2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_refetch_en", imem_en, 1);
    chk("t5_refetch_addr", imem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid_c3", out_valid, 1);
    chk("t5_pc_c3", out_pc, 0);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t5_drained", q.size(), 0);

    // Redirect past the populated words
    do_redirect(32'hCC, 3);
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_valid", out_valid, 1);
    chk("t6_pc", out_pc, 32'hCC);
    chk("t6_ins", out_ins, mk(32'hCC).ins);
    chk("t6_err", out_err, mk(32'hCC).err);
    @(negedge clk);
    chk("t6_next_pc", out_pc, 32'hD0);
    chk("t6_next_err", out_err, mk(32'hD0).err);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t6_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
